gerenciador_voltas: RTL and testbench

Lap (split-time) manager for the stopwatch datapath. Captures the running tenths/seconds count on a lap press, buffers up to PROFUNDIDADE laps, and arbitrates what drives the seven-segment decoder: live count or a stored lap selected in review mode. Sits between the counter outputs (cont_dec/cont_seg) and the display block; takes the counting indication from the state machine.

---
 rtl/gerenciador_voltas.sv | 117 +++++++++++
 tb/tb_gerenciador_voltas.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/gerenciador_voltas.sv
// Lap manager: captures split times into a small ring buffer and muxes live count or a stored lap to the display.
// Optional: define SOBRESCREVER_EN so a full buffer overwrites its oldest lap instead of dropping the new one.
module gerenciador_voltas #(
   parameter  int PROFUNDIDADE = 8,
   parameter  int LARGURA_DEC  = 4,
   parameter  int LARGURA_SEG  = 10,
   localparam int IW           = $clog2(PROFUNDIDADE)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   contando,
   input  logic                   volta,
   input  logic                   revisar,
   input  logic                   limpar,
   input  logic [LARGURA_DEC-1:0] cont_dec,
   input  logic [LARGURA_SEG-1:0] cont_seg,
   output logic [LARGURA_DEC-1:0] dec_disp,
   output logic [LARGURA_SEG-1:0] seg_disp,
   output logic                   modo_revisao,
   output logic [IW-1:0]          indice,
   output logic [IW:0]            num_voltas,
   output logic                   cheio,
   output logic                   vazio
);

`ifdef SOBRESCREVER_EN
   localparam bit SOBRESCREVE = 1'b1;
`else
   localparam bit SOBRESCREVE = 1'b0;
`endif

   typedef struct packed {
      logic [LARGURA_SEG-1:0] seg;
      logic [LARGURA_DEC-1:0] dec;
   } volta_t;

   typedef enum logic {AO_VIVO, REVISAO} estado_t;

   estado_t                    estado, estado_prox;
   logic                       volta_q, revisar_q, limpar_q;
   logic                       r_volta, r_revisar;
   logic                       p_limpar, p_revisar, p_volta;
   logic [IW-1:0]              ptr_esc, ptr_ant;
   volta_t [PROFUNDIDADE-1:0]  mem;
   volta_t                     leitura;
   logic                       captura, sobrepor;
   logic [IW:0]                ultimo;

   always_ff @(posedge clk or posedge reset)
      if (reset) {volta_q, revisar_q, limpar_q} <= '0;
      else       {volta_q, revisar_q, limpar_q} <= {volta, revisar, limpar};

   // Rising-edge pulses, masked so only the highest-priority press of a cycle survives
   assign r_volta   = volta   & ~volta_q;
   assign r_revisar = revisar & ~revisar_q;
   assign p_limpar  = limpar  & ~limpar_q;
   assign p_revisar = r_revisar & ~p_limpar;
   assign p_volta   = r_volta & ~r_revisar & ~p_limpar;

   assign captura  = (estado == AO_VIVO) & p_volta & contando & (~cheio | SOBRESCREVE);
   assign sobrepor = captura & cheio;
   assign ultimo   = num_voltas - (IW+1)'(1);
   assign leitura  = mem[ptr_ant + indice];

   always_ff @(posedge clk or posedge reset)
      if (reset) estado <= AO_VIVO;
      else       estado <= estado_prox;

   always_comb begin
      estado_prox = estado;
      if (p_limpar)
         estado_prox = AO_VIVO;
      else if (p_revisar) begin
         if (estado == REVISAO) estado_prox = AO_VIVO;
         else if (!vazio)       estado_prox = REVISAO;
      end
   end

   always_comb begin
      modo_revisao = (estado == REVISAO);
      cheio        = (num_voltas == (IW+1)'(PROFUNDIDADE));
      vazio        = (num_voltas == '0);
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         ptr_esc    <= '0;
         ptr_ant    <= '0;
         num_voltas <= '0;
         indice     <= '0;
      end else if (p_limpar) begin
         ptr_esc    <= '0;
         ptr_ant    <= '0;
         num_voltas <= '0;
         indice     <= '0;
      end else begin
         if (captura) begin
            ptr_esc <= ptr_esc + 1'b1;
            // Full ring in overwrite mode: oldest slot is recycled, count saturates
            if (sobrepor) ptr_ant    <= ptr_ant + 1'b1;
            else          num_voltas <= num_voltas + 1'b1;
         end
         if (p_revisar)
            indice <= '0;
         else if (p_volta && estado == REVISAO)
            indice <= ({1'b0, indice} == ultimo) ? '0 : indice + 1'b1;
      end

   always_ff @(posedge clk)
      if (captura) mem[ptr_esc] <= {cont_seg, cont_dec};

   always_ff @(posedge clk or posedge reset)
      if (reset)                  {seg_disp, dec_disp} <= '0;
      else if (estado == REVISAO) {seg_disp, dec_disp} <= leitura;
      else                        {seg_disp, dec_disp} <= {cont_seg, cont_dec};

endmodule

// File: tb/tb_gerenciador_voltas.sv
// Bench for gerenciador_voltas: directed test-plan steps then random traffic against a queue-based lap model.
module tb_gerenciador_voltas;
   localparam int P  = 8;
   localparam int LD = 4;
   localparam int LS = 10;
   localparam int IW = 3;
`ifdef SOBRESCREVER_EN
   localparam bit SOBRE = 1'b1;
`else
   localparam bit SOBRE = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          contando = 1'b0, volta = 1'b0, revisar = 1'b0, limpar = 1'b0;
   logic [LD-1:0] cont_dec = '0, dec_disp;
   logic [LS-1:0] cont_seg = '0, seg_disp;
   logic          modo_revisao, cheio, vazio;
   logic [IW-1:0] indice;
   logic [IW:0]   num_voltas;

   int passed = 0, total = 0;

   typedef struct {int seg; int dec;} lap_t;
   lap_t laps[$];
   bit   m_rev;
   int   m_idx;
   bit   pv, pr, pl;
   int   e_dec, e_seg;
   bit   g_c;
   int   g_d, g_s;

   always #5 clk = ~clk;

   gerenciador_voltas #(.PROFUNDIDADE(P), .LARGURA_DEC(LD), .LARGURA_SEG(LS)) dut (
      .clk(clk), .reset(reset), .contando(contando), .volta(volta), .revisar(revisar),
      .limpar(limpar), .cont_dec(cont_dec), .cont_seg(cont_seg), .dec_disp(dec_disp),
      .seg_disp(seg_disp), .modo_revisao(modo_revisao), .indice(indice),
      .num_voltas(num_voltas), .cheio(cheio), .vazio(vazio)
   );

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic check_all(string t);
      chk({t, ".dec_disp"}, 32'(dec_disp), e_dec);
      chk({t, ".seg_disp"}, 32'(seg_disp), e_seg);
      chk({t, ".modo"},     32'(modo_revisao), m_rev);
      chk({t, ".indice"},   32'(indice), m_idx);
      chk({t, ".num"},      32'(num_voltas), laps.size());
      chk({t, ".cheio"},    32'(cheio), laps.size() == P);
      chk({t, ".vazio"},    32'(vazio), laps.size() == 0);
   endtask

   // One clock edge of the lap manager's rules, in terms of an ordered list of laps
   task automatic model(bit v, bit r, bit l, bit c, int d, int s);
      bit pvol, prev, plim;
      if (m_rev) begin e_seg = laps[m_idx].seg; e_dec = laps[m_idx].dec; end
      else       begin e_seg = s;               e_dec = d;               end
      plim = l && !pl;
      prev = r && !pr;
      pvol = v && !pv;
      pv = v; pr = r; pl = l;
      if (plim) begin
         laps.delete(); m_rev = 0; m_idx = 0;
      end else if (prev) begin
         if (m_rev) begin m_rev = 0; m_idx = 0; end
         else if (laps.size() > 0) begin m_rev = 1; m_idx = 0; end
      end else if (pvol) begin
         if (m_rev) m_idx = (m_idx + 1) % laps.size();
         else if (c) begin
            if (laps.size() < P) laps.push_back('{s, d});
            else if (SOBRE) begin void'(laps.pop_front()); laps.push_back('{s, d}); end
         end
      end
   endtask

   task automatic step(bit v, bit r, bit l, string t);
      @(negedge clk);
      volta = v; revisar = r; limpar = l;
      contando = g_c; cont_dec = LD'(g_d); cont_seg = LS'(g_s);
      @(posedge clk);
      model(v, r, l, g_c, g_d, g_s);
      #1;
      check_all(t);
   endtask

   task automatic press(bit v, bit r, bit l, string t);
      step(v, r, l, t);
      step(0, 0, 0, t);
   endtask

   task automatic do_reset(string t);
      @(negedge clk);
      reset = 1'b1; volta = 0; revisar = 0; limpar = 0;
      #1;
      laps.delete(); m_rev = 0; m_idx = 0; pv = 0; pr = 0; pl = 0; e_dec = 0; e_seg = 0;
      check_all(t);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic lap_at(int s, int d, string t);
      g_s = s; g_d = d;
      press(1, 0, 0, t);
   endtask

   initial begin
      g_c = 1; g_d = 0; g_s = 0;
      do_reset("reset");

      // First lap then review
      g_s = 12; g_d = 3;
      step(0, 0, 0, "tp1.idle");
      press(1, 0, 0, "tp1.lap");
      chk("tp1.num1", 32'(num_voltas), 1);
      step(0, 1, 0, "tp1.rev");
      chk("tp1.modo", 32'(modo_revisao), 1);
      step(0, 0, 0, "tp1.show");
      chk("tp1.seg12", 32'(seg_disp), 12);
      chk("tp1.dec3", 32'(dec_disp), 3);
      step(0, 0, 0, "tp1.rel");
      press(0, 0, 1, "tp1.clr");

      // Three laps and stepping through them with wrap
      lap_at(1, 0, "tp2.l1");
      lap_at(2, 5, "tp2.l2");
      lap_at(4, 7, "tp2.l3");
      g_s = 9; g_d = 9;
      press(0, 1, 0, "tp2.rev");
      for (int i = 0; i < 3; i++) press(1, 0, 0, "tp2.step");
      chk("tp2.wrap_idx", 32'(indice), 0);
      chk("tp2.wrap_seg", 32'(seg_disp), 1);
      press(0, 0, 1, "tp2.clr");

      // Not counting: lap ignored, review with no laps ignored
      g_c = 0;
      press(1, 0, 0, "tp3.lap");
      press(0, 1, 0, "tp3.rev");
      chk("tp3.num0", 32'(num_voltas), 0);
      chk("tp3.modo0", 32'(modo_revisao), 0);
      g_c = 1;

      // Nine laps into an eight-deep buffer
      for (int i = 1; i <= 9; i++) lap_at(i, i % 10, "tp4.lap");
      chk("tp4.num8", 32'(num_voltas), 8);
      chk("tp4.cheio", 32'(cheio), 1);
      press(0, 1, 0, "tp4.rev");
      chk("tp4.idx0", 32'(seg_disp), SOBRE ? 2 : 1);
      for (int i = 0; i < 7; i++) press(1, 0, 0, "tp4.step");
      chk("tp4.idx7", 32'(seg_disp), SOBRE ? 9 : 8);
      press(0, 0, 1, "tp4.clr");

      // Simultaneous presses in review: clear wins
      for (int i = 1; i <= 3; i++) lap_at(20 + i, i, "tp5.lap");
      press(0, 1, 0, "tp5.rev");
      g_s = 100; g_d = 7;
      step(1, 1, 1, "tp5.all");
      chk("tp5.vazio", 32'(vazio), 1);
      step(0, 0, 0, "tp5.live");
      chk("tp5.live_seg", 32'(seg_disp), 100);

      // Reset during review
      for (int i = 1; i <= 5; i++) lap_at(30 + i, i, "tp6.lap");
      press(0, 1, 0, "tp6.rev");
      do_reset("tp6.reset");

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 249) == 0) do_reset("rnd.reset");
         g_c = ($urandom_range(0, 3) != 0);
         g_d = $urandom_range(0, 9);
         g_s = $urandom_range(0, 1023);
         step($urandom_range(0, 2) == 0, $urandom_range(0, 6) == 0,
              $urandom_range(0, 40) == 0, "rnd");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
